// File: rtl/act_stream.sv
// act_stream: two-stage streaming activation (identity, ReLU, hard-sigmoid, hard-swish)
// on Q-format elements, with valid/ready backpressure and frame-end tagging.
module act_stream #(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAC_BITS    = 4,
    parameter int NUM_FEATURES = 16,
    parameter int HEIGHT       = 32,
    parameter int WIDTH        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int N      = HEIGHT * WIDTH * NUM_FEATURES;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int T_W    = DATA_WIDTH + 2;
    localparam int PROD_W = 2 * DATA_WIDTH + 18;
    localparam int R6     = 10923;

    localparam logic [CNT_W-1:0]         LAST_IDX = CNT_W'(N - 1);
    localparam logic signed [T_W-1:0]    THREE    = T_W'(3 << FRAC_BITS);
    localparam logic signed [T_W-1:0]    SIX      = T_W'(6 << FRAC_BITS);
    localparam logic signed [PROD_W-1:0] R6_W     = PROD_W'(R6);
    localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [1:0] {
        MODE_IDENTITY = 2'd0,
        MODE_RELU     = 2'd1,
        MODE_HSIGMOID = 2'd2,
        MODE_HSWISH   = 2'd3
    } mode_t;

    logic                         en;
    logic                         accept;
    logic [CNT_W-1:0]             count;
    mode_t                        mode_q;
    mode_t                        mode_eff;

    logic signed [DATA_WIDTH-1:0] x_in;
    logic signed [DATA_WIDTH-1:0] relu_in;
    logic signed [T_W-1:0]        x_ext;
    logic signed [T_W-1:0]        t_sum;
    logic signed [T_W-1:0]        t_clamp;

    logic                         s1_valid;
    logic signed [DATA_WIDTH-1:0] s1_x;
    logic signed [DATA_WIDTH-1:0] s1_relu;
    logic signed [T_W-1:0]        s1_t;
    mode_t                        s1_mode;
    logic                         s1_last;

    logic signed [PROD_W-1:0]     x_w;
    logic signed [PROD_W-1:0]     t_w;
    logic signed [PROD_W-1:0]     sig_prod;
    logic signed [PROD_W-1:0]     swish_prod;
    logic signed [PROD_W-1:0]     sig_res;
    logic signed [PROD_W-1:0]     swish_res;
    logic [DATA_WIDTH-1:0]        act_res;

    logic                         s2_valid;

    function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [PROD_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[DATA_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            return v[DATA_WIDTH-1:0];
        end
    endfunction

    assign en        = !s2_valid || out_ready;
    assign in_ready  = en;
    assign accept    = in_valid && en;
    assign out_valid = s2_valid;
    assign busy      = (count != '0) || s1_valid || s2_valid;

    // The first element of a frame uses the mode presented with it; later elements use the latched copy.
    assign mode_eff = (count == '0) ? mode_t'(mode) : mode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            mode_q <= MODE_IDENTITY;
        end else if (accept) begin
            if (count == '0) begin
                mode_q <= mode_t'(mode);
            end
            count <= (count == LAST_IDX) ? '0 : count + CNT_W'(1);
        end
    end

    assign x_in    = $signed(in_data);
    assign x_ext   = {{(T_W - DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
    assign t_sum   = x_ext + THREE;
    assign relu_in = x_in[DATA_WIDTH-1] ? '0 : x_in;

    always_comb begin
        t_clamp = t_sum;
        if (t_sum[T_W-1]) begin
            t_clamp = '0;
        end else if (t_sum > SIX) begin
            t_clamp = SIX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_relu  <= '0;
            s1_t     <= '0;
            s1_mode  <= MODE_IDENTITY;
            s1_last  <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_x     <= x_in;
            s1_relu  <= relu_in;
            s1_t     <= t_clamp;
            s1_mode  <= mode_eff;
            s1_last  <= in_valid && (count == LAST_IDX);
        end
    end

    // Products are carried at full width so the floor shift sees the exact value.
    assign x_w        = {{(PROD_W - DATA_WIDTH){s1_x[DATA_WIDTH-1]}}, s1_x};
    assign t_w        = {{(PROD_W - T_W){s1_t[T_W-1]}}, s1_t};
    assign sig_prod   = t_w * R6_W;
    assign swish_prod = x_w * t_w * R6_W;
    assign sig_res    = sig_prod >>> 16;
    assign swish_res  = swish_prod >>> (16 + FRAC_BITS);

    always_comb begin
        act_res = s1_x;
        case (s1_mode)
            MODE_RELU:     act_res = s1_relu;
            MODE_HSIGMOID: act_res = saturate(sig_res);
            MODE_HSWISH:   act_res = saturate(swish_res);
            default:       act_res = s1_x;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            out_data <= act_res;
            out_last <= s1_valid && s1_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && out_last;
        end
    end

endmodule

// File: tb/tb_act_stream.sv
// Self-checking bench for act_stream: directed activation points, backpressure, reset
// mid-flight and multi-frame random handshaking against a behavioural scoreboard.
`timescale 1ns/1ps
module tb_act_stream;

    localparam int DW    = 8;
    localparam int FB    = 4;
    localparam int FRAME = 32 * 32 * 16;
    localparam int THREE = 3 << FB;
    localparam int SIX   = 6 << FB;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          frame_done;
    logic          busy;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t expQ[$];
    int   gotQ[$];
    int   vecCount  = 0;
    int   errCount  = 0;
    int   readyPct  = 100;
    int   modelCount = 0;
    int   modelMode  = 0;
    bit   expFd     = 1'b0;
    bit   holdValid = 1'b0;
    int   holdData  = 0;
    bit   holdLast  = 1'b0;
    int   lastSeen  = 0;
    int   fdSeen    = 0;

    always #5 clk = ~clk;

    act_stream #(
        .DATA_WIDTH(DW), .FRAC_BITS(FB), .NUM_FEATURES(16), .HEIGHT(32), .WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .frame_done(frame_done), .busy(busy)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic longint floorDiv(input longint a, input longint b);
        longint q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Activation computed directly from the Q-format definitions.
    function automatic int actRef(input int m, input int x);
        longint t;
        longint v;
        t = x + THREE;
        if (t < 0) t = 0;
        else if (t > SIX) t = SIX;
        case (m)
            0:       v = x;
            1:       v = (x < 0) ? 0 : x;
            2:       v = floorDiv(t * 10923, longint'(1) << 16);
            default: v = floorDiv(longint'(x) * t * 10923, longint'(1) << (16 + FB));
        endcase
        if (v > (2 ** (DW - 1)) - 1) v = (2 ** (DW - 1)) - 1;
        else if (v < -(2 ** (DW - 1))) v = -(2 ** (DW - 1));
        return int'(v);
    endfunction

    task automatic monitorLoop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                expQ.delete();
                modelCount = 0;
                modelMode  = 0;
                expFd      = 1'b0;
                holdValid  = 1'b0;
            end else begin
                checkOutput("frame_done", int'(frame_done), int'(expFd));
                expFd = 1'b0;
                if (frame_done) fdSeen++;
                if (out_valid) begin
                    if (holdValid) begin
                        checkOutput("hold_data", int'($signed(out_data)), holdData);
                        checkOutput("hold_last", int'(out_last), int'(holdLast));
                    end
                    if (out_ready) begin
                        holdValid = 1'b0;
                        if (expQ.size() == 0) begin
                            checkOutput("extra_output", 1, 0);
                        end else begin
                            e = expQ.pop_front();
                            checkOutput("out_data", int'($signed(out_data)), e.data);
                            checkOutput("out_last", int'(out_last), int'(e.last));
                            expFd = e.last;
                            gotQ.push_back(int'($signed(out_data)));
                            if (out_last) lastSeen++;
                        end
                    end else begin
                        holdValid = 1'b1;
                        holdData  = int'($signed(out_data));
                        holdLast  = out_last;
                    end
                end else begin
                    if (holdValid) checkOutput("valid_dropped", 0, 1);
                    holdValid = 1'b0;
                end
                if (in_valid && in_ready) begin
                    if (modelCount == 0) modelMode = int'(mode);
                    e.data = actRef(modelMode, int'($signed(in_data)));
                    e.last = (modelCount == FRAME - 1);
                    expQ.push_back(e);
                    modelCount = (modelCount + 1) % FRAME;
                end
            end
        end
    endtask

    task automatic readyLoop();
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(99) < readyPct);
        end
    endtask

    // Called and returns at 1 ns after a rising edge.
    task automatic applyStimulus(input int value, input int gapPct);
        int waitCycles = 0;
        while ($urandom_range(99) < gapPct) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = value[DW-1:0];
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waitCycles++;
            if (waitCycles > 200) begin
                checkOutput("in_ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((expQ.size() != 0 || busy) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) checkOutput("drain_timeout", expQ.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic runDirected(input int m, input int ins[$], input int outs[$], input string tag);
        doReset();
        mode = m[1:0];
        gotQ.delete();
        foreach (ins[i]) applyStimulus(ins[i], 0);
        drain();
        checkOutput({tag, "_count"}, gotQ.size(), outs.size());
        foreach (outs[i]) begin
            if (i < gotQ.size()) checkOutput(tag, gotQ[i], outs[i]);
        end
    endtask

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int qi[$];
        int qo[$];
        int hs[5];

        rst = 1'b0; mode = 2'd0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        doReset();
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_data", int'(out_data), 0);
        checkOutput("reset_out_last", int'(out_last), 0);
        checkOutput("reset_frame_done", int'(frame_done), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        fork
            monitorLoop();
            readyLoop();
        join_none

        // Hard-swish points with a two-cycle latency check on the first element.
        mode = 2'd3;
        gotQ.delete();
        in_valid = 1'b1;
        in_data  = 8'd48;
        @(negedge clk);
        checkOutput("lat_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("lat_cycle1_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("lat_cycle2_valid", int'(out_valid), 1);
        @(posedge clk);
        #1;
        applyStimulus(-64, 0);
        applyStimulus(16, 0);
        applyStimulus(-16, 0);
        applyStimulus(127, 0);
        drain();
        hs = '{48, 0, 10, -6, 127};
        checkOutput("hswish_count", gotQ.size(), 5);
        foreach (hs[i]) begin
            if (i < gotQ.size()) checkOutput("hswish", gotQ[i], hs[i]);
        end

        qi = '{48, -48, 0};  qo = '{16, 0, 8};
        runDirected(2, qi, qo, "hsig");
        qi = '{-5, 7};       qo = '{0, 7};
        runDirected(1, qi, qo, "relu");
        qi = '{-128};        qo = '{-128};
        runDirected(0, qi, qo, "ident");

        // Backpressure: downstream stalls while the source streams continuously.
        doReset();
        mode = 2'd3;
        gotQ.delete();
        readyPct = 0;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 12; i++) applyStimulus(int'($urandom_range(255)), 0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                @(negedge clk);
                checkOutput("bp_in_ready", int'(in_ready), 0);
                checkOutput("bp_out_valid", int'(out_valid), 1);
                readyPct = 100;
            end
        join
        drain();
        checkOutput("bp_count", gotQ.size(), 12);

        // Reset with two elements in flight and the counter at 100.
        doReset();
        mode = 2'd2;
        for (int i = 0; i < 98; i++) applyStimulus(int'($urandom_range(255)), 20);
        drain();
        readyPct = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        applyStimulus(int'($urandom_range(255)), 0);
        applyStimulus(int'($urandom_range(255)), 0);
        checkOutput("inflight_busy", int'(busy), 1);
        checkOutput("inflight_out_valid", int'(out_valid), 1);
        doReset();
        mode = 2'd3;
        readyPct = 100;
        for (int i = 0; i < 20; i++) applyStimulus(int'($urandom_range(255)), 0);
        drain();

        // Full frame at full rate; the mid-frame mode change must not take effect.
        doReset();
        mode = 2'd3;
        lastSeen = 0;
        fdSeen   = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i == FRAME / 2) mode = 2'd1;
            applyStimulus(int'($urandom_range(255)), 0);
        end
        drain();
        checkOutput("frame1_last_count", lastSeen, 1);
        checkOutput("frame1_done_count", fdSeen, 1);

        // Two more frames with random valid/ready toggling and random mode changes.
        readyPct = 85;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < FRAME; i++) begin
                if (f == 1 && i == 0) mode = 2'd3;
                else if ($urandom_range(999) == 0) mode = 2'($urandom_range(3));
                applyStimulus(int'($urandom_range(255)), 10);
            end
        end
        readyPct = 100;
        drain();
        checkOutput("frames_last_count", lastSeen, 3);
        checkOutput("frames_done_count", fdSeen, 3);
        checkOutput("scoreboard_empty", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
